w_stage_grf: RTL and testbench
==============================

# w_stage_grf

Write-back stage of the five-stage MIPS32 pipeline: the M/W pipeline register, the write-data multiplexer and the 32×32 general register file (GRF). It captures the M-stage results every cycle and presents the registered W-stage instruction to the W-stage decoder. It takes the decoded write controls back from that decoder and commits one register write per cycle. It also serves the two D-stage read ports, with internal write-to-read bypass.

## Interface
- `LINK_OFFSET`, default 8: byte offset added to the W-stage PC to form the jal link value.
- `RESET_PC`, default 32'h0000_3000: reset value of the registered W-stage PC.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `m_instr` input 32: M-stage instruction word.
- `m_pc` input 32: M-stage instruction address.
- `m_alu` input 32: M-stage ALU result.
- `m_dm` input 32: M-stage data-memory read data.
- `w_instr` output 32: registered instruction, fed to the W-stage decoder.
- `w_pc` output 32: registered PC.
- `w_regwrite` input 1: from decoder; W-stage instruction writes the GRF.
- `w_a3` input 5: from decoder; destination register.
- `w_memtoreg` input 1: from decoder; write data comes from the memory word.
- `w_jalop` input 1: from decoder; write data is the link address.
- `w_wd` output 32: selected write data (forwarding source).
- `w_fwd_a3` output 5: `w_a3` when `w_regwrite`=1, else 0 (hazard-unit address).
- `d_ra1`, `d_ra2` input 5 each: D-stage read addresses (rs, rt).
- `d_rd1`, `d_rd2` output 32 each: D-stage read data.

## Operation
- Pipeline register: on every rising edge (no stall, no flush) `w_instr`/`w_pc`/internal `w_alu`/`w_dm` load `m_instr`/`m_pc`/`m_alu`/`m_dm`.
- A bubble is injected upstream as `m_instr`=0. An all-zero word is sll $0 and decodes to regwrite=0.
- Write-data select, priority order:
  - `w_jalop`=1 → `w_pc + LINK_OFFSET`, 32-bit, wrap-around modulo 2^32.
  - else `w_memtoreg`=1 → `w_dm`.
  - else → `w_alu`.
- `w_wd` shows the selected value even when `w_regwrite`=0.
- GRF write: on the rising edge, if `w_regwrite`=1 and `w_a3`≠0, then `GRF[w_a3]` ← `w_wd`.
  - A write to $0 is discarded.
  - `GRF[0]` reads 0 at all times.
- Read ports are combinational. Per port, for address `ra`:
  - `ra`=0 → 0.
  - else if `w_regwrite`=1 and `w_a3`=`ra` → `w_wd` (same-cycle bypass).
  - else → `GRF[ra]`.
- Both ports are independent. Both may bypass in the same cycle.
- Simulation trace: for every committed write, emit one line `@<w_pc hex8>: $<w_a3 dec2> <= <w_wd hex8>` at that edge. Discarded $0 writes print nothing. Verification diffs this trace against the golden model.

## Timing
- Reset values:
  - `w_instr`=0, `w_pc`=`RESET_PC`, `w_alu`=0, `w_dm`=0.
  - All 32 GRF entries = 0.
  - Therefore `w_wd`=0, `w_fwd_a3`=0, `d_rd1`=`d_rd2`=0.
- Reset is asynchronous. Asserting it mid-cycle clears state at once, without waiting for an edge. A write that coincides with a reset-active edge is suppressed.
- Latency:
  - An M-stage value appears on the W outputs one edge after it is presented.
  - It is committed to the GRF at the following edge.
  - Via bypass, it is visible on `d_rd*` during the cycle it sits in W.
- Write-then-read of the same register:
  - Same cycle → bypass value.
  - Next cycle → GRF value (identical).
- Each W-stage instruction writes at most once.
- Back-to-back writes to one register: the last committed value wins.
- `w_fwd_a3`=0 means "no producer in W". Tnew is 0 for every W-stage producer.

## Test plan
- Reset: hold `reset`=1, then release.
  - Expect `w_pc`=0x00003000, `w_instr`=0.
  - Expect all GRF reads 0 for `ra` 0..31.
- ALU write + bypass:
  - Stimulus: M = addu $3 with `m_alu`=0x12345678; set decoder inputs regwrite=1, a3=3; `d_ra1`=3 during the W cycle.
  - Expect `d_rd1`=0x12345678 in that cycle.
  - Expect `GRF[3]`=0x12345678 afterwards.
  - Expect trace `@…: $ 3 <= 12345678`.
- lw select:
  - Stimulus: `m_alu`=0xAAAA0000, `m_dm`=0xDEADBEEF; memtoreg=1, a3=8.
  - Expect `GRF[8]`=0xDEADBEEF, not the ALU value.
- jal link and wrap-around:
  - Stimulus: `m_pc`=0x00003010, jalop=1, a3=31.
  - Expect `GRF[31]`=0x00003018.
  - Stimulus: `m_pc`=0xFFFFFFFC.
  - Expect 0x00000004.
- $0 protection: regwrite=1, a3=0, `w_wd`=0xFFFFFFFF.
  - Expect `d_rd1`(ra=0)=0.
  - Expect no trace line.
  - Expect `w_fwd_a3`=0.
- Async reset mid-stream:
  - Stimulus: pulse `reset` between edges after `GRF[5]`=0x55 is written.
  - Expect `d_rd2`(ra=5) to drop to 0 before the next edge.
  - Expect `w_pc` to return to 0x00003000.

Source files
------------

// File: rtl/w_stage_grf.sv
// w_stage_grf: M/W pipeline register, write-data select and 32x32 general register file.
// Latency: M values reach the W outputs one edge after they are presented and commit to the GRF at the next edge.
// Backpressure: none. The register loads every cycle; the read ports bypass the in-flight W write.
// Ports:
//   clk, reset        : clock and async active-high reset
//   m_instr/m_pc/m_alu/m_dm : M-stage results captured each edge
//   w_instr, w_pc     : registered W-stage instruction and PC for the decoder
//   w_regwrite, w_a3, w_memtoreg, w_jalop : decoded write controls from the decoder
//   w_wd, w_fwd_a3    : selected write data and hazard-unit producer address
//   d_ra1/d_ra2 -> d_rd1/d_rd2 : D-stage combinational read ports
module w_stage_grf #(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter logic [31:0] RESET_PC    = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_instr,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_alu,
  input  logic [31:0] m_dm,
  output logic [31:0] w_instr,
  output logic [31:0] w_pc,
  input  logic        w_regwrite,
  input  logic [4:0]  w_a3,
  input  logic        w_memtoreg,
  input  logic        w_jalop,
  output logic [31:0] w_wd,
  output logic [4:0]  w_fwd_a3,
  input  logic [4:0]  d_ra1,
  input  logic [4:0]  d_ra2,
  output logic [31:0] d_rd1,
  output logic [31:0] d_rd2
);

  logic [31:0] w_instr_q;
  logic [31:0] w_pc_q;
  logic [31:0] w_alu_q;
  logic [31:0] w_dm_q;
  logic [31:0] grf_q [32];
  logic [31:0] wd_d;
  logic        we_d;

  // M/W pipeline register: no stall or flush, bubbles arrive as m_instr = 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_instr_q <= 32'd0;
      w_pc_q    <= RESET_PC;
      w_alu_q   <= 32'd0;
      w_dm_q    <= 32'd0;
    end else begin
      w_instr_q <= m_instr;
      w_pc_q    <= m_pc;
      w_alu_q   <= m_alu;
      w_dm_q    <= m_dm;
    end
  end

  // Link has priority over memory data, which has priority over the ALU result.
  // The link sum wraps modulo 2^32.
  always_comb begin
    wd_d = w_alu_q;
    if (w_jalop) begin
      wd_d = w_pc_q + LINK_OFFSET;
    end else if (w_memtoreg) begin
      wd_d = w_dm_q;
    end
  end

  // Writes to $0 are dropped here, so entry 0 stays at its reset value of zero.
  assign we_d = w_regwrite && (w_a3 != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        grf_q[i] <= 32'd0;
      end
    end else if (we_d) begin
      grf_q[w_a3] <= wd_d;
    end
  end

  // Read ports: $0 is hard zero. A matching W write is bypassed so D sees it in the same cycle.
  always_comb begin
    d_rd1 = grf_q[d_ra1];
    if (d_ra1 == 5'd0) begin
      d_rd1 = 32'd0;
    end else if (w_regwrite && (w_a3 == d_ra1)) begin
      d_rd1 = wd_d;
    end
  end

  always_comb begin
    d_rd2 = grf_q[d_ra2];
    if (d_ra2 == 5'd0) begin
      d_rd2 = 32'd0;
    end else if (w_regwrite && (w_a3 == d_ra2)) begin
      d_rd2 = wd_d;
    end
  end

  assign w_instr  = w_instr_q;
  assign w_pc     = w_pc_q;
  assign w_wd     = wd_d;
  // Zero tells the hazard unit there is no producer in W.
  assign w_fwd_a3 = w_regwrite ? w_a3 : 5'd0;

endmodule

// File: tb/tb_w_stage_grf.sv
// tb_w_stage_grf: directed self-checking bench for w_stage_grf.
// Latency: stimulus is applied 1 ns after an edge and outputs are sampled before the next edge.
// Backpressure: not applicable. Decoder controls are driven directly by the bench.
module tb_w_stage_grf;

  logic        clk;
  logic        reset;
  logic [31:0] m_instr, m_pc, m_alu, m_dm;
  logic [31:0] w_instr, w_pc, w_wd;
  logic        w_regwrite, w_memtoreg, w_jalop;
  logic [4:0]  w_a3, w_fwd_a3, d_ra1, d_ra2;
  logic [31:0] d_rd1, d_rd2;

  int checks = 0;
  int errors = 0;

  // Commit trace, plus a capture of the last committed write.
  int          trace_count = 0;
  logic [31:0] tr_pc, tr_wd;
  logic [4:0]  tr_a3;

  w_stage_grf dut (
    .clk(clk), .reset(reset),
    .m_instr(m_instr), .m_pc(m_pc), .m_alu(m_alu), .m_dm(m_dm),
    .w_instr(w_instr), .w_pc(w_pc),
    .w_regwrite(w_regwrite), .w_a3(w_a3), .w_memtoreg(w_memtoreg), .w_jalop(w_jalop),
    .w_wd(w_wd), .w_fwd_a3(w_fwd_a3),
    .d_ra1(d_ra1), .d_ra2(d_ra2), .d_rd1(d_rd1), .d_rd2(d_rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && w_regwrite && (w_a3 != 5'd0)) begin
      $display("@%08h: $%2d <= %08h", w_pc, w_a3, w_wd);
      trace_count = trace_count + 1;
      tr_pc = w_pc;
      tr_a3 = w_a3;
      tr_wd = w_wd;
    end
  end

  task automatic present(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] dm);
    m_instr = instr; m_pc = pc; m_alu = alu; m_dm = dm;
    @(posedge clk); #1;
  endtask

  task automatic set_ctl(input logic rw, input logic [4:0] a3,
                         input logic mtr, input logic jal);
    w_regwrite = rw; w_a3 = a3; w_memtoreg = mtr; w_jalop = jal;
  endtask

  task automatic commit();
    @(posedge clk); #1;
    set_ctl(1'b0, 5'd0, 1'b0, 1'b0);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_ctl(1'b0, 5'd0, 1'b0, 1'b0);
    m_instr = 32'h0; m_pc = 32'h0; m_alu = 32'h0; m_dm = 32'h0;
    d_ra1 = 5'd0; d_ra2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (w_pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_w_pc got=%08h exp=00003000", w_pc); end
    checks++; if (w_instr !== 32'h0) begin errors++; $display("FAIL reset_w_instr got=%08h exp=00000000", w_instr); end
    checks++; if (w_wd !== 32'h0) begin errors++; $display("FAIL reset_w_wd got=%08h exp=00000000", w_wd); end
    checks++; if (w_fwd_a3 !== 5'd0) begin errors++; $display("FAIL reset_fwd_a3 got=%0d exp=0", w_fwd_a3); end
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 32; r++) begin
      d_ra1 = 5'(r); d_ra2 = 5'(31 - r);
      #1;
      checks++; if (d_rd1 !== 32'h0) begin errors++; $display("FAIL reset_rd1[%0d] got=%08h exp=00000000", r, d_rd1); end
      checks++; if (d_rd2 !== 32'h0) begin errors++; $display("FAIL reset_rd2[%0d] got=%08h exp=00000000", 31 - r, d_rd2); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu_write();
    int tc;
    present(32'h0022_1821, 32'h0000_3000, 32'h1234_5678, 32'h0);
    checks++; if (w_instr !== 32'h0022_1821) begin errors++; $display("FAIL alu_w_instr got=%08h exp=00221821", w_instr); end
    set_ctl(1'b1, 5'd3, 1'b0, 1'b0);
    d_ra1 = 5'd3;
    #1;
    checks++; if (d_rd1 !== 32'h1234_5678) begin errors++; $display("FAIL alu_bypass got=%08h exp=12345678", d_rd1); end
    checks++; if (w_fwd_a3 !== 5'd3) begin errors++; $display("FAIL alu_fwd_a3 got=%0d exp=3", w_fwd_a3); end
    tc = trace_count;
    commit();
    checks++; if (trace_count !== tc + 1) begin errors++; $display("FAIL alu_trace_count got=%0d exp=%0d", trace_count, tc + 1); end
    checks++; if (tr_a3 !== 5'd3 || tr_wd !== 32'h1234_5678 || tr_pc !== 32'h0000_3000)
      begin errors++; $display("FAIL alu_trace got=@%08h $%0d <= %08h exp=@00003000 $3 <= 12345678", tr_pc, tr_a3, tr_wd); end
    checks++; if (d_rd1 !== 32'h1234_5678) begin errors++; $display("FAIL alu_grf3 got=%08h exp=12345678", d_rd1); end
  endtask

  task automatic test_lw_select();
    present(32'h8C08_0000, 32'h0000_3004, 32'hAAAA_0000, 32'hDEAD_BEEF);
    set_ctl(1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    checks++; if (w_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_wd got=%08h exp=deadbeef", w_wd); end
    commit();
    d_ra2 = 5'd8; #1;
    checks++; if (d_rd2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_grf8 got=%08h exp=deadbeef", d_rd2); end
  endtask

  task automatic test_jal_link();
    present(32'h0C00_0C10, 32'h0000_3010, 32'h5555_5555, 32'h6666_6666);
    set_ctl(1'b1, 5'd31, 1'b1, 1'b1);
    #1;
    checks++; if (w_wd !== 32'h0000_3018) begin errors++; $display("FAIL jal_wd got=%08h exp=00003018", w_wd); end
    commit();
    d_ra1 = 5'd31; #1;
    checks++; if (d_rd1 !== 32'h0000_3018) begin errors++; $display("FAIL jal_grf31 got=%08h exp=00003018", d_rd1); end
    present(32'h0C00_0000, 32'hFFFF_FFFC, 32'h0, 32'h0);
    set_ctl(1'b1, 5'd31, 1'b0, 1'b1);
    #1;
    checks++; if (w_wd !== 32'h0000_0004) begin errors++; $display("FAIL jal_wrap_wd got=%08h exp=00000004", w_wd); end
    commit();
    checks++; if (d_rd1 !== 32'h0000_0004) begin errors++; $display("FAIL jal_wrap_grf31 got=%08h exp=00000004", d_rd1); end
  endtask

  task automatic test_zero_reg();
    int tc;
    present(32'h0000_0000, 32'h0000_3020, 32'hFFFF_FFFF, 32'h0);
    set_ctl(1'b1, 5'd0, 1'b0, 1'b0);
    d_ra1 = 5'd0;
    #1;
    checks++; if (w_wd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL zero_wd got=%08h exp=ffffffff", w_wd); end
    checks++; if (d_rd1 !== 32'h0) begin errors++; $display("FAIL zero_bypass got=%08h exp=00000000", d_rd1); end
    checks++; if (w_fwd_a3 !== 5'd0) begin errors++; $display("FAIL zero_fwd_a3 got=%0d exp=0", w_fwd_a3); end
    tc = trace_count;
    commit();
    checks++; if (trace_count !== tc) begin errors++; $display("FAIL zero_trace_count got=%0d exp=%0d", trace_count, tc); end
    checks++; if (d_rd1 !== 32'h0) begin errors++; $display("FAIL zero_grf0 got=%08h exp=00000000", d_rd1); end
  endtask

  task automatic test_no_write_and_dual_bypass();
    // Controls say no write, so $3 must still read its GRF value and no producer is shown.
    present(32'h0, 32'h0000_3024, 32'h0BAD_0BAD, 32'h0);
    set_ctl(1'b0, 5'd3, 1'b0, 1'b0);
    d_ra1 = 5'd3;
    #1;
    checks++; if (d_rd1 !== 32'h1234_5678) begin errors++; $display("FAIL nowrite_rd1 got=%08h exp=12345678", d_rd1); end
    checks++; if (w_fwd_a3 !== 5'd0) begin errors++; $display("FAIL nowrite_fwd_a3 got=%0d exp=0", w_fwd_a3); end
    // Both ports bypass the same W producer.
    present(32'h0, 32'h0000_3028, 32'h9999_0009, 32'h0);
    set_ctl(1'b1, 5'd9, 1'b0, 1'b0);
    d_ra1 = 5'd9; d_ra2 = 5'd9;
    #1;
    checks++; if (d_rd1 !== 32'h9999_0009) begin errors++; $display("FAIL dual_rd1 got=%08h exp=99990009", d_rd1); end
    checks++; if (d_rd2 !== 32'h9999_0009) begin errors++; $display("FAIL dual_rd2 got=%08h exp=99990009", d_rd2); end
    commit();
  endtask

  task automatic test_async_reset();
    present(32'h0, 32'h0000_3030, 32'h0000_0055, 32'h0);
    set_ctl(1'b1, 5'd5, 1'b0, 1'b0);
    commit();
    d_ra2 = 5'd5;
    present(32'h0, 32'h0000_3040, 32'h0, 32'h0);
    checks++; if (d_rd2 !== 32'h0000_0055) begin errors++; $display("FAIL areset_pre_grf5 got=%08h exp=00000055", d_rd2); end
    // Mid-cycle pulse, well before the next rising edge.
    #1 reset = 1'b1;
    #1;
    checks++; if (d_rd2 !== 32'h0) begin errors++; $display("FAIL areset_grf5 got=%08h exp=00000000", d_rd2); end
    checks++; if (w_pc !== 32'h0000_3000) begin errors++; $display("FAIL areset_w_pc got=%08h exp=00003000", w_pc); end
    // A write presented while reset is held across an edge must be suppressed.
    set_ctl(1'b1, 5'd6, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    set_ctl(1'b0, 5'd0, 1'b0, 1'b0);
    d_ra1 = 5'd6; #1;
    checks++; if (d_rd1 !== 32'h0) begin errors++; $display("FAIL areset_suppress_grf6 got=%08h exp=00000000", d_rd1); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_lw_select();
    test_jal_link();
    test_zero_reg();
    test_no_write_and_dual_bypass();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
